// File: rtl/vram_arb_pkg.sv
// Shared identifiers and tag types for the three-requester VRAM arbiter.
package vram_arb_pkg;

  localparam int unsigned NUM_REQ = 3;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_LINE = 2'd0;
  localparam req_id_t REQ_DRAW = 2'd1;
  localparam req_id_t REQ_HOST = 2'd2;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rsp_tag_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  // Round-robin pointer lands on whichever of draw/host was not just served.
  function automatic req_id_t rr_other(input req_id_t id);
    return (id == REQ_DRAW) ? REQ_HOST : REQ_DRAW;
  endfunction

endpackage

// File: rtl/vram_arb_rsp_pipe.sv
// Read-tag delay line: tracks which requester owns each read in flight and
// pulses that requester's rsp_valid when the memory data is due.
module vram_arb_rsp_pipe
  import vram_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic               clk_draw,
  input  logic               rst_n_draw,
  input  logic               issue_rd,
  input  logic [1:0]         issue_id,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic               rsp_load_c
);

  localparam int unsigned DEPTH = RD_LAT + 1;

  rsp_tag_t stage_q [DEPTH];

  always_ff @(posedge clk_draw) begin
    if (!rst_n_draw) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      rsp_valid <= '0;
    end else begin
      stage_q[0] <= '{valid: issue_rd, id: issue_id};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      rsp_valid <= stage_q[DEPTH-1].valid ? id_onehot(stage_q[DEPTH-1].id) : '0;
    end
  end

  // Last stage lines up with mem_rdata; the top captures rsp_data on it.
  assign rsp_load_c = stage_q[DEPTH-1].valid;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: line fetch has fixed priority, draw and host share
// round-robin. Define VRAM_ARB_STARVE_EN to add the draw/host starvation guard.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic                        clk_draw,
  input  logic                        rst_n_draw,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  if ((RD_LAT < 1) || (RD_LAT > 4) || (STARVE_MAX < 1)) begin : g_param_check
    $error("vram_arbiter: RD_LAT must be 1..4 and STARVE_MAX at least 1");
  end

  req_id_t rr_q;
  req_id_t gnt_id_c;
  logic    gnt_c;
  logic    rd_issue_c;
  logic    rsp_load_c;
  logic    sat_draw_c;
  logic    sat_host_c;

`ifdef VRAM_ARB_STARVE_EN
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] wait_draw_q;
  logic [CNT_W-1:0] wait_host_q;

  assign sat_draw_c = req_valid[REQ_DRAW] && (wait_draw_q == CNT_W'(STARVE_MAX));
  assign sat_host_c = req_valid[REQ_HOST] && (wait_host_q == CNT_W'(STARVE_MAX));

  // Wait counters saturate so a starved requester keeps its override until served.
  always_ff @(posedge clk_draw) begin
    if (!rst_n_draw) begin
      wait_draw_q <= '0;
      wait_host_q <= '0;
    end else begin
      if (!req_valid[REQ_DRAW] || (gnt_c && (gnt_id_c == REQ_DRAW))) begin
        wait_draw_q <= '0;
      end else if (wait_draw_q != CNT_W'(STARVE_MAX)) begin
        wait_draw_q <= wait_draw_q + CNT_W'(1);
      end
      if (!req_valid[REQ_HOST] || (gnt_c && (gnt_id_c == REQ_HOST))) begin
        wait_host_q <= '0;
      end else if (wait_host_q != CNT_W'(STARVE_MAX)) begin
        wait_host_q <= wait_host_q + CNT_W'(1);
      end
    end
  end
`else
  assign sat_draw_c = 1'b0;
  assign sat_host_c = 1'b0;
`endif

  // Grant selection: starvation override, then line fetch, then round-robin.
  always_comb begin
    gnt_id_c = REQ_LINE;
    if (sat_draw_c && sat_host_c) begin
      gnt_id_c = rr_q;
    end else if (sat_draw_c) begin
      gnt_id_c = REQ_DRAW;
    end else if (sat_host_c) begin
      gnt_id_c = REQ_HOST;
    end else if (req_valid[REQ_LINE]) begin
      gnt_id_c = REQ_LINE;
    end else if (req_valid[REQ_DRAW] && req_valid[REQ_HOST]) begin
      gnt_id_c = rr_q;
    end else if (req_valid[REQ_DRAW]) begin
      gnt_id_c = REQ_DRAW;
    end else if (req_valid[REQ_HOST]) begin
      gnt_id_c = REQ_HOST;
    end
    gnt_c      = rst_n_draw && (req_valid != '0);
    req_ready  = gnt_c ? id_onehot(gnt_id_c) : '0;
    rd_issue_c = gnt_c && !req_we[gnt_id_c];
  end

  always_ff @(posedge clk_draw) begin
    if (!rst_n_draw) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_data  <= '0;
      rr_q      <= REQ_DRAW;
    end else begin
      mem_en <= gnt_c;
      mem_we <= gnt_c && req_we[gnt_id_c];
      if (gnt_c) begin
        mem_addr  <= req_addr[gnt_id_c*ADDR_W +: ADDR_W];
        mem_wdata <= req_wdata[gnt_id_c*DATA_W +: DATA_W];
      end
      if (gnt_c && (gnt_id_c != REQ_LINE)) begin
        rr_q <= rr_other(gnt_id_c);
      end
      if (rsp_load_c) begin
        rsp_data <= mem_rdata;
      end
    end
  end

  vram_arb_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk_draw   (clk_draw),
    .rst_n_draw (rst_n_draw),
    .issue_rd   (rd_issue_c),
    .issue_id   (gnt_id_c),
    .rsp_valid  (rsp_valid),
    .rsp_load_c (rsp_load_c)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic scored
// against a cycle-indexed expectation table built from the arbitration rules.
module tb_vram_arbiter;

  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 15;
  localparam int NCYC       = 4096;
`ifdef VRAM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk_draw = 1'b0;
  logic        rst_n_draw;
  logic [2:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [47:0] req_addr, req_wdata;
  logic [15:0] rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;

  int total = 0;
  int bad   = 0;

  always #5 clk_draw = ~clk_draw;

  vram_arbiter #(
    .ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_draw(clk_draw), .rst_n_draw(rst_n_draw),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory with RD_LAT read latency; idle cycles return noise.
  logic [15:0] tb_mem [logic [15:0]];
  logic [15:0] rd_pipe [RD_LAT];
  always @(posedge clk_draw) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) tb_mem[mem_addr] = mem_wdata;
    rd_pipe[0] <= (mem_en === 1'b1 && mem_we === 1'b0)
                  ? (tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : init_word(mem_addr))
                  : 16'($urandom);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model state
  logic [15:0] mdl_mem [logic [15:0]];
  int m_rr = 1, m_w1 = 0, m_w2 = 0, cyc = 0;
  logic        exp_known [NCYC];
  logic        exp_zero  [NCYC];
  logic        exp_en    [NCYC];
  logic        exp_we    [NCYC];
  logic [15:0] exp_addr  [NCYC];
  logic [15:0] exp_wd    [NCYC];
  logic [15:0] exp_rd    [NCYC];
  logic [2:0]  exp_rv    [NCYC];

  function automatic logic [15:0] mdl_read(input logic [15:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
  endfunction

  function automatic int model_grant(input logic [2:0] v, input int rr, input int w1, input int w2);
    bit s1, s2;
    s1 = STARVE && v[1] && (w1 >= STARVE_MAX);
    s2 = STARVE && v[2] && (w2 >= STARVE_MAX);
    if (s1 && s2) return rr;
    if (s1) return 1;
    if (s2) return 2;
    if (v[0]) return 0;
    if (v[1] && v[2]) return rr;
    if (v[1]) return 1;
    if (v[2]) return 2;
    return -1;
  endfunction

  // Scoreboard: check this cycle against the table, then extend the table.
  always @(negedge clk_draw) begin
    int g;
    logic [2:0] exp_ready;
    logic [15:0] a, d;
    if (exp_known[cyc]) begin
      total++;
      if (mem_en !== exp_en[cyc]) begin bad++; $display("FAIL sb_mem_en cyc=%0d got=%b want=%b", cyc, mem_en, exp_en[cyc]); end
      total++;
      if (mem_we !== exp_we[cyc]) begin bad++; $display("FAIL sb_mem_we cyc=%0d got=%b want=%b", cyc, mem_we, exp_we[cyc]); end
      if (exp_en[cyc]) begin
        total++;
        if (mem_addr !== exp_addr[cyc]) begin bad++; $display("FAIL sb_mem_addr cyc=%0d got=%h want=%h", cyc, mem_addr, exp_addr[cyc]); end
      end
      if (exp_we[cyc]) begin
        total++;
        if (mem_wdata !== exp_wd[cyc]) begin bad++; $display("FAIL sb_mem_wdata cyc=%0d got=%h want=%h", cyc, mem_wdata, exp_wd[cyc]); end
      end
      total++;
      if (rsp_valid !== exp_rv[cyc]) begin bad++; $display("FAIL sb_rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, exp_rv[cyc]); end
      if (exp_rv[cyc] != 3'b000) begin
        total++;
        if (rsp_data !== exp_rd[cyc]) begin bad++; $display("FAIL sb_rsp_data cyc=%0d got=%h want=%h", cyc, rsp_data, exp_rd[cyc]); end
      end
      if (exp_zero[cyc]) begin
        total++;
        if ({mem_addr, mem_wdata, rsp_data} !== 48'h0) begin
          bad++; $display("FAIL sb_post_reset cyc=%0d got addr=%h wdata=%h rdata=%h want all 0", cyc, mem_addr, mem_wdata, rsp_data);
        end
      end
    end
    g = rst_n_draw ? model_grant(req_valid, m_rr, m_w1, m_w2) : -1;
    exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
    total++;
    if (req_ready !== exp_ready) begin bad++; $display("FAIL sb_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready); end
    if (!rst_n_draw) begin
      for (int k = 1; k <= RD_LAT + 3; k++) begin
        exp_en[cyc+k] = 1'b0; exp_we[cyc+k] = 1'b0; exp_rv[cyc+k] = 3'b000; exp_zero[cyc+k] = 1'b0;
      end
      exp_known[cyc+1] = 1'b1;
      exp_zero[cyc+1]  = 1'b1;
      m_rr = 1; m_w1 = 0; m_w2 = 0;
    end else begin
      exp_known[cyc+1] = 1'b1;
      exp_zero[cyc+1]  = 1'b0;
      exp_en[cyc+1]    = (g >= 0);
      exp_we[cyc+1]    = 1'b0;
      if (g >= 0) begin
        a = req_addr[g*16 +: 16];
        d = req_wdata[g*16 +: 16];
        exp_addr[cyc+1] = a;
        exp_wd[cyc+1]   = d;
        if (req_we[g]) begin
          exp_we[cyc+1] = 1'b1;
          mdl_mem[a] = d;
        end else begin
          exp_rv[cyc+2+RD_LAT] = 3'(1 << g);
          exp_rd[cyc+2+RD_LAT] = mdl_read(a);
        end
      end
      if (req_valid[1] && g != 1) m_w1 = (m_w1 < STARVE_MAX) ? m_w1 + 1 : m_w1; else m_w1 = 0;
      if (req_valid[2] && g != 2) m_w2 = (m_w2 < STARVE_MAX) ? m_w2 + 1 : m_w2; else m_w2 = 0;
      if (g == 1) m_rr = 2;
      else if (g == 2) m_rr = 1;
    end
    if (cyc < NCYC - 16) cyc++;
  end

  task automatic next_cycle();
    @(posedge clk_draw);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
    req_valid[i] = v;
    req_we[i]    = w;
    req_addr[i*16 +: 16]  = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic idle(input int n);
    req_valid = 3'b000;
    req_we    = 3'b000;
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    rst_n_draw = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 16'(i), 16'h0);
    repeat (3) begin
      @(negedge clk_draw);
      total++;
      if (req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b want=000", req_ready); end
      total++;
      if ({mem_en, mem_we, rsp_valid, mem_addr, mem_wdata, rsp_data} !== 53'h0) begin
        bad++; $display("FAIL rst_outputs got en=%b we=%b rv=%b addr=%h wd=%h rd=%h want all 0",
                        mem_en, mem_we, rsp_valid, mem_addr, mem_wdata, rsp_data);
      end
      next_cycle();
    end
    rst_n_draw = 1'b1;
    req_valid = 3'b010;
    @(negedge clk_draw);
    total++;
    if (req_ready !== 3'b010) begin bad++; $display("FAIL rst_first_hs got=%b want=010", req_ready); end
    next_cycle();
  endtask

  task automatic test_single_read();
    idle(6);
    set_req(1, 1'b1, 1'b0, 16'h0040, 16'h0);
    @(negedge clk_draw);
    total++;
    if (req_ready !== 3'b010) begin bad++; $display("FAIL rd_ready got=%b want=010", req_ready); end
    next_cycle();
    req_valid = 3'b000;
    @(negedge clk_draw);
    total++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
      bad++; $display("FAIL rd_issue got en=%b we=%b addr=%h want 1 0 0040", mem_en, mem_we, mem_addr);
    end
    next_cycle(); next_cycle();
    @(negedge clk_draw);
    total++;
    if (rsp_valid !== 3'b000) begin bad++; $display("FAIL rd_early got=%b want=000", rsp_valid); end
    next_cycle();
    @(negedge clk_draw);
    total++;
    if (rsp_valid !== 3'b010) begin bad++; $display("FAIL rd_rsp_valid got=%b want=010", rsp_valid); end
    total++;
    if (rsp_data !== init_word(16'h0040)) begin bad++; $display("FAIL rd_rsp_data got=%h want=%h", rsp_data, init_word(16'h0040)); end
    next_cycle();
  endtask

  task automatic test_write();
    idle(6);
    set_req(2, 1'b1, 1'b1, 16'h1234, 16'hBEEF);
    @(negedge clk_draw);
    total++;
    if (req_ready !== 3'b100) begin bad++; $display("FAIL wr_ready got=%b want=100", req_ready); end
    next_cycle();
    req_valid = 3'b000;
    req_we    = 3'b000;
    @(negedge clk_draw);
    total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h1234, 16'hBEEF}) begin
      bad++; $display("FAIL wr_issue got en=%b we=%b addr=%h wd=%h want 1 1 1234 beef", mem_en, mem_we, mem_addr, mem_wdata);
    end
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk_draw);
      total++;
      if (rsp_valid !== 3'b000) begin bad++; $display("FAIL wr_no_rsp t+%0d got=%b want=000", k, rsp_valid); end
      next_cycle();
    end
    set_req(0, 1'b1, 1'b0, 16'h1234, 16'h0);
    next_cycle();
    req_valid = 3'b000;
    repeat (3) next_cycle();
    @(negedge clk_draw);
    total++;
    if ({rsp_valid, rsp_data} !== {3'b001, 16'hBEEF}) begin
      bad++; $display("FAIL wr_readback got rv=%b data=%h want 001 beef", rsp_valid, rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_conflict();
    logic [2:0] prev, want;
    idle(6);
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 16'h0300 + 16'(i), 16'h0);
    repeat (3) begin
      @(negedge clk_draw);
      total++;
      if (req_ready !== 3'b001) begin bad++; $display("FAIL cf_line_hold got=%b want=001", req_ready); end
      next_cycle();
    end
    req_valid[0] = 1'b0;
    prev = 3'b000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_draw);
      total++;
      if (k == 0) begin
        if (req_ready !== 3'b010 && req_ready !== 3'b100) begin
          bad++; $display("FAIL cf_first_rr got=%b want=010|100", req_ready);
        end
      end else begin
        want = (prev == 3'b010) ? 3'b100 : 3'b010;
        if (req_ready !== want) begin bad++; $display("FAIL cf_alternate k=%0d got=%b want=%b", k, req_ready, want); end
      end
      prev = req_ready;
      next_cycle();
    end
    idle(6);
  endtask

  task automatic test_stream();
    logic [15:0] base;
    base = 16'h2000;
    idle(6);
    for (int k = 0; k < 12; k++) begin
      if (k < 8) set_req(0, 1'b1, 1'b0, base + 16'(k), 16'h0);
      else req_valid = 3'b000;
      @(negedge clk_draw);
      if (k < 8) begin
        total++;
        if (req_ready !== 3'b001) begin bad++; $display("FAIL st_ready k=%0d got=%b want=001", k, req_ready); end
      end
      if (k >= 1 && k <= 8) begin
        total++;
        if ({mem_en, mem_addr} !== {1'b1, base + 16'(k - 1)}) begin
          bad++; $display("FAIL st_issue k=%0d got en=%b addr=%h want 1 %h", k, mem_en, mem_addr, base + 16'(k - 1));
        end
      end
      if (k >= 4) begin
        total++;
        if ({rsp_valid, rsp_data} !== {3'b001, init_word(base + 16'(k - 4))}) begin
          bad++; $display("FAIL st_rsp k=%0d got rv=%b data=%h want 001 %h", k, rsp_valid, rsp_data, init_word(base + 16'(k - 4)));
        end
      end
      next_cycle();
    end
    idle(4);
  endtask

  task automatic test_starve();
    logic [2:0] want;
    idle(4);
    set_req(0, 1'b1, 1'b0, 16'h0500, 16'h0);
    set_req(1, 1'b1, 1'b0, 16'h0600, 16'h0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_draw);
      want = (STARVE && k == STARVE_MAX + 1) ? 3'b010 : 3'b001;
      total++;
      if (req_ready !== want) begin bad++; $display("FAIL sv_grant cycle=%0d got=%b want=%b", k, req_ready, want); end
      next_cycle();
    end
    idle(6);
  endtask

  task automatic test_reset_mid_read();
    idle(6);
    set_req(1, 1'b1, 1'b0, 16'h0100, 16'h0);
    @(negedge clk_draw);
    total++;
    if (req_ready !== 3'b010) begin bad++; $display("FAIL rm_ready got=%b want=010", req_ready); end
    next_cycle();
    req_valid = 3'b000;
    next_cycle();
    rst_n_draw = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h0101, 16'h0);
    @(negedge clk_draw);
    total++;
    if (req_ready !== 3'b000) begin bad++; $display("FAIL rm_ready_in_reset got=%b want=000", req_ready); end
    next_cycle();
    rst_n_draw = 1'b1;
    req_valid  = 3'b000;
    @(negedge clk_draw);
    total++;
    if ({req_ready, rsp_valid, mem_en, mem_we, mem_addr, mem_wdata, rsp_data} !== 56'h0) begin
      bad++; $display("FAIL rm_outputs got rdy=%b rv=%b en=%b we=%b addr=%h wd=%h rd=%h want all 0",
                      req_ready, rsp_valid, mem_en, mem_we, mem_addr, mem_wdata, rsp_data);
    end
    for (int k = 4; k <= 7; k++) begin
      next_cycle();
      @(negedge clk_draw);
      total++;
      if (rsp_valid !== 3'b000) begin bad++; $display("FAIL rm_no_rsp t+%0d got=%b want=000", k, rsp_valid); end
    end
    next_cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst_n_draw = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < 3; i++) begin
        set_req(i, ($urandom_range(0, 2) != 0) && (i != 0 || $urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 16'h8000 + 16'($urandom_range(0, 15)), 16'($urandom));
      end
      @(negedge clk_draw);
      total++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 3'b000) begin
        bad++; $display("FAIL rnd_ready_shape n=%0d got=%b valid=%b", n, req_ready, req_valid);
      end
      next_cycle();
    end
    rst_n_draw = 1'b1;
    idle(10);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      exp_known[i] = 1'b0; exp_zero[i] = 1'b0; exp_en[i] = 1'b0; exp_we[i] = 1'b0;
      exp_addr[i] = '0; exp_wd[i] = '0; exp_rd[i] = '0; exp_rv[i] = '0;
    end
    rst_n_draw = 1'b0;
    req_valid  = 3'b000;
    req_we     = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    test_reset();
    test_single_read();
    test_write();
    test_conflict();
    test_stream();
    test_starve();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
